// File: rtl/spike_rate_decoder.sv
// Rate decoder for the output neuron: counts spikes over a fixed window, records the first-spike
// latency and thresholds the count into a single result bit offered over valid/ready.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_CYCLES      = 64,
  parameter int unsigned COUNT_WIDTH        = 8,
  parameter int unsigned LAT_WIDTH          = 8,
  parameter int unsigned DECISION_THRESHOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_bit,
  output logic [COUNT_WIDTH-1:0] spike_count,
  output logic [LAT_WIDTH-1:0]   first_spike_lat
);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StHold
  } state_e;

  localparam logic [LAT_WIDTH-1:0]   WinLen   = LAT_WIDTH'(WINDOW_CYCLES);
  localparam logic [LAT_WIDTH-1:0]   LastIdx  = LAT_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e                 state_q, state_d;
  logic [LAT_WIDTH-1:0]   idx_q, idx_d;
  logic [LAT_WIDTH-1:0]   lat_q, lat_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   result_bit_q, result_bit_d;
  logic [COUNT_WIDTH-1:0] count_sat;

  always_comb begin
    count_sat = (count_q == CountMax) ? count_q : count_q + COUNT_WIDTH'(1);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    count_d      = count_q;
    result_bit_d = result_bit_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCount;
          idx_d   = '0;
          count_d = '0;
          lat_d   = WinLen;
        end
      end
      StCount: begin
        if (spike_in) begin
          count_d = count_sat;
          // lat still at WinLen means no spike yet; a live index never reaches WinLen
          if (lat_q == WinLen) begin
            lat_d = idx_q;
          end
        end
        idx_d = idx_q + LAT_WIDTH'(1);
        if (idx_q == LastIdx) begin
          state_d      = StHold;
          result_bit_d = (32'(count_d) >= DECISION_THRESHOLD);
        end
      end
      StHold: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      lat_q        <= '0;
      count_q      <= '0;
      result_bit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      count_q      <= count_d;
      result_bit_q <= result_bit_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign result_valid    = (state_q == StHold);
  assign result_bit      = result_bit_q;
  assign spike_count     = count_q;
  assign first_spike_lat = lat_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: default decoder, a 4-bit-counter variant and a one-sample-window variant.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: defaults
  logic       start_a = 0, spike_a = 0, ready_a = 0;
  logic       busy_a, valid_a, bit_a;
  logic [7:0] count_a, lat_a;
  // Instance B: 4-bit saturating counter
  logic       start_b = 0, spike_b = 0, ready_b = 0;
  logic       busy_b, valid_b, bit_b;
  logic [3:0] count_b;
  logic [7:0] lat_b;
  // Instance C: single-sample window
  logic       start_c = 0, spike_c = 0, ready_c = 0;
  logic       busy_c, valid_c, bit_c;
  logic [7:0] count_c, lat_c;

  spike_rate_decoder u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .spike_in(spike_a), .busy(busy_a),
    .result_valid(valid_a), .result_ready(ready_a), .result_bit(bit_a),
    .spike_count(count_a), .first_spike_lat(lat_a)
  );

  spike_rate_decoder #(.COUNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .spike_in(spike_b), .busy(busy_b),
    .result_valid(valid_b), .result_ready(ready_b), .result_bit(bit_b),
    .spike_count(count_b), .first_spike_lat(lat_b)
  );

  spike_rate_decoder #(.WINDOW_CYCLES(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .spike_in(spike_c), .busy(busy_c),
    .result_valid(valid_c), .result_ready(ready_c), .result_bit(bit_c),
    .spike_count(count_c), .first_spike_lat(lat_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_a(input logic spk_on_start);
    start_a = 1'b1;
    spike_a = spk_on_start;
    step();
    start_a = 1'b0;
    check("a_busy_rise", 32'(busy_a), 32'd1);
  endtask

  task automatic feed_a(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      spike_a = pat[i];
      step();
    end
    spike_a = 1'b0;
  endtask

  task automatic finish_a(input logic [63:0] pat);
    feed_a(pat, 63);
    check("a_valid_early", 32'(valid_a), 32'd0);
    spike_a = pat[63];
    step();
    spike_a = 1'b0;
    check("a_valid_rise", 32'(valid_a), 32'd1);
  endtask

  task automatic handshake_a();
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    check("a_valid_drop", 32'(valid_a), 32'd0);
    check("a_busy_drop", 32'(busy_a), 32'd0);
  endtask

  task automatic expect_a(input string tag, input int cnt, input int lat, input logic rb);
    check({tag, "_count"}, 32'(count_a), 32'(cnt));
    check({tag, "_lat"}, 32'(lat_a), 32'(lat));
    check({tag, "_bit"}, 32'(bit_a), 32'(rb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pat;
    logic        saw;

    // Reset with random start/spike activity
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a = 1'($urandom); spike_a = 1'($urandom);
      start_b = 1'($urandom); spike_b = 1'($urandom);
      start_c = 1'($urandom); spike_c = 1'($urandom);
      step();
    end
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    expect_a("rst", 0, 0, 1'b0);
    check("rst_b_count", 32'(count_b), 32'd0);
    start_a = 0; spike_a = 0; start_b = 0; spike_b = 0; start_c = 0; spike_c = 0;
    rst = 1'b0;
    step();

    // Spikes at indices 3, 10, 20
    pat = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20);
    begin_a(1'b0);
    finish_a(pat);
    expect_a("three", 3, 3, 1'b1);
    handshake_a();
    check("idle_keep_count", 32'(count_a), 32'd3);
    step();

    // No spikes in window, spike on the start edge only
    begin_a(1'b1);
    finish_a(64'd0);
    expect_a("none", 0, 64, 1'b0);
    handshake_a();

    // Single spike at the last index, then backpressure
    begin_a(1'b0);
    finish_a(64'd1 << 63);
    expect_a("last", 1, 63, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start_a = (i % 2 == 0);
      spike_a = (i % 2 != 0);
      step();
      check("bp_valid", 32'(valid_a), 32'd1);
      expect_a("bp", 1, 63, 1'b0);
    end
    start_a = 1'b1;
    spike_a = 1'b1;
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    check("bp_valid_drop", 32'(valid_a), 32'd0);
    check("bp_start_ignored", 32'(busy_a), 32'd0);
    step();
    start_a = 1'b0;
    check("bp_restart_busy", 32'(busy_a), 32'd1);
    check("bp_restart_lat", 32'(lat_a), 32'd64);
    // Two spikes meets the threshold exactly
    finish_a(64'h3);
    expect_a("thr_edge", 2, 0, 1'b1);
    handshake_a();

    // Reset in the middle of a window
    begin_a(1'b0);
    feed_a(64'd1 << 5, 30);
    rst = 1'b1;
    spike_a = 1'b1;
    step();
    rst = 1'b0;
    spike_a = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    expect_a("mid_rst", 0, 0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      saw = saw | valid_a;
    end
    check("mid_rst_no_valid", 32'(saw), 32'd0);
    begin_a(1'b0);
    finish_a((64'd1 << 7) | (64'd1 << 40));
    expect_a("post_rst", 2, 7, 1'b1);
    handshake_a();

    // Saturation on the 4-bit counter
    start_b = 1'b1;
    spike_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 64; i++) step();
    spike_b = 1'b0;
    check("sat_valid", 32'(valid_b), 32'd1);
    check("sat_count", 32'(count_b), 32'd15);
    check("sat_lat", 32'(lat_b), 32'd0);
    check("sat_bit", 32'(bit_b), 32'd1);
    ready_b = 1'b1;
    step();
    ready_b = 1'b0;
    check("sat_valid_drop", 32'(valid_b), 32'd0);

    // One-sample window
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    check("w1_valid_early", 32'(valid_c), 32'd0);
    check("w1_busy", 32'(busy_c), 32'd1);
    spike_c = 1'b1;
    step();
    spike_c = 1'b0;
    check("w1_valid", 32'(valid_c), 32'd1);
    check("w1_count", 32'(count_c), 32'd1);
    check("w1_lat", 32'(lat_c), 32'd0);
    check("w1_bit", 32'(bit_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder at the output end of the spiking pipeline, the counterpart to the input spike encoders. It observes the single-bit spike train from the output neuron over a fixed-length window and counts the spikes. It also records the latency of the first spike, then reduces the window to a binary result (for example the XOR answer). The result is presented with a valid/ready handshake to the downstream controller or testbench.

## Interface
- WINDOW_CYCLES, 64: number of spike_in samples per decode window; legal range 1 to 2^LAT_WIDTH-1.
- COUNT_WIDTH, 8: width of the spike counter; the counter saturates at 2^COUNT_WIDTH-1.
- LAT_WIDTH, 8: width of the first-spike latency and window-index counters.
- DECISION_THRESHOLD, 2: result_bit is 1 when spike_count >= DECISION_THRESHOLD; unsigned.

Ports:
- clk  in  1  Single clock; all logic on posedge.
- rst  in  1  Reset, synchronous and active-high; one clock, synchronous active-high reset.
- start  in  1  Request to begin a window; honoured only in IDLE.
- spike_in  in  1  Spike train from the output neuron; each cycle high counts as one spike.
- busy  out  1  High in COUNT and HOLD.
- result_valid  out  1  High in HOLD.
- result_ready  in  1  Downstream accept.
- result_bit  out  1  Decoded binary value.
- spike_count  out  COUNT_WIDTH  Spikes in the last window.
- first_spike_lat  out  LAT_WIDTH  Sample index of the first spike in the window; WINDOW_CYCLES if no spike occurred.

## Operation
- FSM states:
  - IDLE to COUNT on start.
  - COUNT to HOLD after WINDOW_CYCLES samples.
  - HOLD to IDLE when result_valid && result_ready.
- IDLE:
  - start=1 clears spike_count to 0, window index to 0, and first_spike_lat to WINDOW_CYCLES.
  - Outputs otherwise keep their last values.
- COUNT, one sample per cycle:
  - If spike_in=1, spike_count increments, saturating at all-ones.
  - If spike_in=1 and this is the first spike of the window, first_spike_lat takes the current window index (0-based).
  - The window index increments each cycle. The sample taken at index WINDOW_CYCLES-1 is the last; the FSM then moves to HOLD.
- result_bit is registered on entry to HOLD as (final spike_count >= DECISION_THRESHOLD). The comparison is unsigned and uses the saturated count.
- HOLD:
  - result_bit, spike_count and first_spike_lat stay stable.
  - start and spike_in are ignored.
- Any start outside IDLE is dropped and not queued.
- rst has priority over all other inputs.

## Timing
- Reset values: state IDLE, busy=0, result_valid=0, result_bit=0, spike_count=0, first_spike_lat=0. The internal window index is also 0.
- Reset asserted mid-COUNT or mid-HOLD aborts the window; no result is produced. The next start after rst deasserts behaves normally.
- Window timing, with start sampled high in IDLE at edge t:
  - busy=1 from cycle t+1.
  - spike_in is sampled at edges t+1 through t+WINDOW_CYCLES.
  - A spike coinciding with the start edge t is not counted.
- Latency: result_valid rises in cycle t+WINDOW_CYCLES+1.
- Handshake:
  - Completion occurs at the first edge with result_valid=1 and result_ready=1.
  - At the next cycle result_valid=0, busy=0, state IDLE.
  - result_ready high while valid is low has no effect.
- A start on the same edge as handshake completion is ignored, because the FSM is still in HOLD. The earliest next start is accepted one cycle later.
- Back-to-back throughput: one window per WINDOW_CYCLES+2 cycles when result_ready is tied high.
- WINDOW_CYCLES=1: exactly one sample is taken; result_valid appears at t+2.

## Test plan
- Reset: hold rst for 3 cycles with random start/spike_in -> all outputs 0, busy 0.
- Defaults, start at t, spikes at window indices 3, 10 and 20 -> at t+65: result_valid=1, spike_count=3, result_bit=1, first_spike_lat=3.
- No spikes, plus a spike on the start cycle itself -> spike_count=0, result_bit=0, first_spike_lat=64.
- COUNT_WIDTH=4, spike_in held high for the whole window -> spike_count=15 (saturated), first_spike_lat=0, result_bit=1.
- Single spike at index 63 with DECISION_THRESHOLD=2 -> spike_count=1, first_spike_lat=63, result_bit=0.
- Backpressure:
  - Stimulus: hold result_ready=0 for 10 cycles in HOLD, pulse start and toggle spike_in, then raise result_ready.
  - Required: outputs unchanged throughout; valid and busy drop the next cycle; a start 1 cycle later opens a new window.
- Reset mid-window: assert rst at window index 30 -> result_valid never asserts, state is IDLE; a following start produces a correct result.
